psram_qpi_responder: RTL
========================

Name: psram_qpi_responder

Overview:
- Synthesizable PSRAM device-side model: the responder end of the QPI link driven by the Wishbone PSRAM controller.
- Decodes Enter-QPI (0x35, SPI), Quad Read (0xEB) and Quad Write (0x38) from sck/ce_n/sio, backed by an internal byte array.
- Used in SoC simulation/FPGA builds in place of an external PSRAM chip; sits directly on the controller's sck/ce_n/din/dout/douten pins.

Parameters:
- ADDR_W, 16, byte-address bits implemented; array is 2**ADDR_W bytes; upper command address bits ignored.
- READ_DUMMY, 6, dummy sck cycles between last address nibble and first read data nibble.

Ports:
- clk  input  1  system clock; sck/ce_n/sio_i are synchronous to it, no synchronizers.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  serial clock from controller, at most clk/2.
- ce_n  input  1  chip enable, active low.
- sio_i  input  4  data from controller (controller dout).
- sio_o  output  4  data to controller (controller din).
- sio_oe  output  4  output enable, all bits equal.
- qpi_mode  output  1  1 = device in QPI mode.
- busy  output  1  1 while ce_n low and a transaction is in progress.

Behaviour:
- Edges: sck_q registered each clk; rise = sck & ~sck_q, fall = ~sck & sck_q. Inputs sampled on rise, outputs updated on fall.
- Reset: qpi_mode=0, sio_o=0, sio_oe=0, busy=0, state IDLE, counters 0. Array contents not reset.
- ce_n high at any time: state -> IDLE next clk, sio_oe=0, counters cleared, partial byte discarded; qpi_mode and array kept.
- States:
  - IDLE: on ce_n low -> SPI_CMD if qpi_mode=0, else Q_CMD.
  - SPI_CMD: shift sio_i[0] MSB first on 8 rises; if byte==0x35, set qpi_mode=1 on 8th rise; -> IGNORE.
  - Q_CMD: 2 nibbles, high first. 0xEB -> Q_ADDR(read); 0x38 -> Q_ADDR(write); other -> IGNORE.
  - Q_ADDR: 6 nibbles MSB first into 24-bit addr; array index = addr[ADDR_W-1:0]; -> Q_DUMMY (read) or Q_WDATA (write).
  - Q_DUMMY: READ_DUMMY rises, then -> Q_RDATA.
  - Q_RDATA: on each fall, drive next nibble, high nibble of mem[addr] first, sio_oe=4'hF. Controller samples rise READ_DUMMY+9 onward (rise 15 at default). After low nibble, addr+1.
  - Q_WDATA: nibble pair per byte, high first; write mem[addr] on rise of low nibble, then addr+1. Byte lanes in address order.
  - IGNORE: no response until ce_n high.
- busy = (state != IDLE).
- sio_oe asserted only in Q_RDATA.
- Address increment wraps modulo 2**ADDR_W; no page boundary.
- Reads and writes unlimited length until ce_n high.
- ce_n rise and sck edge in same clk: ce_n wins, edge ignored.
- rst_n assertion mid-transaction: immediate abort; qpi_mode returns 0, so the controller must re-issue 0x35.

Optional Feature:
- Macro: PSRAM_RESP_QPI_EXIT_EN.
- Defined: in Q_CMD, 0xF5 clears qpi_mode on the second command nibble rise, then -> IGNORE.
- Undefined: 0xF5 treated as unknown command (IGNORE); qpi_mode leaves 1 only on reset.

Test Plan:
- Reset, SPI-send 0x35 -> qpi_mode=1 after 8th rise; sio_oe stays 0.
- QPI write 0x38, addr 0x000010, bytes 78 56 34 12 -> mem[0x10..0x13]=78,56,34,12; sio_oe=0 throughout.
- QPI read 0xEB, addr 0x000010, 8 data nibbles -> 7,8,5,6,3,4,1,2 sampled on rises 15-22; sio_oe=F from fall after rise 14 until ce_n high.
- Write at 0x00FFFF with 2 bytes AA BB (ADDR_W=16) -> mem[0xFFFF]=AA, mem[0x0000]=BB.
- Write 0x38 at 0x20, ce_n high after 3 data nibbles (A,B,C) -> mem[0x20]=AB, mem[0x21] unchanged; next command decodes normally.
- Command 0x9F in QPI -> no sio_oe, busy until ce_n high; with PSRAM_RESP_QPI_EXIT_EN, 0xF5 -> qpi_mode=0.

Source files
------------

// File: rtl/psram_qpi_responder.sv
// Device-side PSRAM QPI responder: decodes 0x35 (SPI), 0xEB/0x38 (QPI) against an internal byte array.
// Optional macro PSRAM_RESP_QPI_EXIT_EN makes QPI command 0xF5 drop the device back to SPI mode.
module psram_qpi_responder #(
  parameter int ADDR_W     = 16,
  parameter int READ_DUMMY = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe,
  output logic       qpi_mode,
  output logic       busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] DUMMY_LAST = 8'(READ_DUMMY - 1);

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, Q_CMD, Q_ADDR, Q_DUMMY, Q_RDATA, Q_WDATA, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        sck_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  sr_q, sr_d;
  logic [23:0] addr_q, addr_d;
  logic        is_write_q, is_write_d;
  logic        nib_q, nib_d;
  logic [3:0]  sio_o_q, sio_o_d;
  logic [3:0]  sio_oe_q, sio_oe_d;
  logic        qpi_mode_q, qpi_mode_d;

  logic              rise, fall;
  logic [7:0]        spi_byte, nib_pair;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [0:DEPTH-1];

  assign rise     = sck & ~sck_q;
  assign fall     = ~sck & sck_q;
  assign spi_byte = {sr_q, sio_i[0]};
  assign nib_pair = {sr_q[3:0], sio_i};
  assign mem_addr = addr_q[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    nib_d      = nib_q;
    sio_o_d    = sio_o_q;
    sio_oe_d   = sio_oe_q;
    qpi_mode_d = qpi_mode_q;
    mem_we     = 1'b0;

    if (ce_n) begin
      // Deselect overrides any sck edge seen in the same cycle.
      state_d    = IDLE;
      cnt_d      = '0;
      sr_d       = '0;
      addr_d     = '0;
      is_write_d = 1'b0;
      nib_d      = 1'b0;
      sio_o_d    = '0;
      sio_oe_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = qpi_mode_q ? Q_CMD : SPI_CMD;
        end
        SPI_CMD: if (rise) begin
          sr_d  = spi_byte[6:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            if (spi_byte == 8'h35) qpi_mode_d = 1'b1;
            state_d = IGNORE;
          end
        end
        Q_CMD: if (rise) begin
          if (cnt_q == 8'd0) begin
            sr_d  = {3'b000, sio_i};
            cnt_d = 8'd1;
          end else begin
            cnt_d = '0;
            case (nib_pair)
              8'hEB: begin state_d = Q_ADDR; is_write_d = 1'b0; end
              8'h38: begin state_d = Q_ADDR; is_write_d = 1'b1; end
`ifdef PSRAM_RESP_QPI_EXIT_EN
              8'hF5: begin state_d = IGNORE; qpi_mode_d = 1'b0; end
`endif
              default: state_d = IGNORE;
            endcase
          end
        end
        Q_ADDR: if (rise) begin
          addr_d = {addr_q[19:0], sio_i};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d = '0;
            if (is_write_q)            state_d = Q_WDATA;
            else if (READ_DUMMY == 0)  state_d = Q_RDATA;
            else                       state_d = Q_DUMMY;
          end
        end
        Q_DUMMY: if (rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = '0;
            state_d = Q_RDATA;
          end
        end
        Q_RDATA: if (fall) begin
          // rd_data_q tracks addr_q one clk behind; sck <= clk/2 keeps it settled by the next fall.
          sio_oe_d = 4'hF;
          sio_o_d  = nib_q ? rd_data_q[3:0] : rd_data_q[7:4];
          nib_d    = ~nib_q;
          if (nib_q) addr_d = addr_q + 24'd1;
        end
        Q_WDATA: if (rise) begin
          if (!nib_q) begin
            sr_d  = {3'b000, sio_i};
            nib_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + 24'd1;
            nib_d  = 1'b0;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      nib_q      <= 1'b0;
      sio_o_q    <= '0;
      sio_oe_q   <= '0;
      qpi_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      nib_q      <= nib_d;
      sio_o_q    <= sio_o_d;
      sio_oe_q   <= sio_oe_d;
      qpi_mode_q <= qpi_mode_d;
    end
  end

  // Array contents survive reset, so it lives in its own reset-free process.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= nib_pair;
    rd_data_q <= mem[mem_addr];
  end

  assign sio_o    = sio_o_q;
  assign sio_oe   = sio_oe_q;
  assign qpi_mode = qpi_mode_q;
  assign busy     = (state_q != IDLE);

endmodule
